inv_mix_cols_sequencer: RTL and testbench
=========================================

// Module: inv_mix_cols_sequencer
// PURPOSE
//  Sequences one shared reverse_mix_cols (InvMixColumns, one 32-bit column) over a full
//  128-bit AES state, one column per cycle, for the decryption round datapath.
//  Sits between InvSubBytes/InvShiftRows/AddRoundKey output and the next round register.
//  Uses valid/ready handshakes on both sides; a bypass flag skips mixing for the final round.
// PARAMETERS
//  NUM_COLS   4    columns per state (fixed at 4 for AES-128; other values unsupported)
//  COL_W      32   column width in bits; STATE_W = NUM_COLS*COL_W = 128
// PORTS
//  clk         in   1    rising-edge clock, single clock domain
//  reset       in   1    synchronous, active-high reset
//  in_valid    in   1    in_state/in_bypass are valid
//  in_ready    out  1    block can accept a state
//  in_state    in   128  state; column c = in_state[127-32c -: 32], col 0 = bytes s0..s3
//  in_bypass   in   1    1 = pass state through unmixed (final decrypt round)
//  out_valid   out  1    out_state is valid; held until out_ready
//  out_ready   in   1    downstream accepts out_state
//  out_state   out  128  mixed (or bypassed) state, same column layout as in_state
//  busy        out  1    1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, col_idx=0.
//  FSM: IDLE -> RUN (accept, bypass=0) | IDLE -> DONE (accept, bypass=1);
//       RUN -> DONE after col_idx==NUM_COLS-1; DONE -> IDLE on out_valid && out_ready.
//  Accept = in_valid && in_ready; in_ready = (state==IDLE) only. in_state latched on accept.
//  RUN: each cycle drive input_col = latched column col_idx to reverse_mix_cols; register
//   final_col into out_state column col_idx that same edge; col_idx += 1 (2-bit, wraps to 0).
//  Latency: accept edge T -> out_valid high after edge T+4 (mix), after edge T+1 (bypass).
//  Bypass: out_state <= in_state unchanged on accept edge.
//  out_state/out_valid stable while out_valid && !out_ready; no data change in DONE.
//  Throughput: one state per 6 cycles (mix) or 3 cycles (bypass) with out_ready held 1.
//  in_valid asserted while busy: ignored, no accept; upstream holds it (standard handshake).
//  in_valid in DONE same cycle as out_ready: not accepted; accepted next cycle in IDLE.
//  reset during RUN/DONE: abort, partial result discarded, all outputs to reset values.
//  Arithmetic lives entirely in reverse_mix_cols (GF(2^8), 0e/0b/0d/09 matrix); this
//   block performs no arithmetic besides col_idx increment.
// STRUCTURE
//  Package aes_pkg: COL_W, NUM_COLS, STATE_W constants; typedef fsm_t {IDLE,RUN,DONE};
//   function col_sel(state,idx) for column slicing shared with other column sequencers.
//  One sub-module instance: reverse_mix_cols (existing, combinational, ports input_col /
//   final_col). FSM, col_idx counter, input latch and output register stay in this module.
// TESTING
//  1 Reset: hold reset 2 cycles -> in_ready=1, out_valid=0, busy=0, out_state=0.
//  2 Mix: in_state=416e1899_8e4da1bc_9fdc589d_d5d5d7d6, bypass=0, out_ready=1 ->
//    out_valid exactly 4 cycles after accept edge,
//    out_state=c9dad76a_db135345_f20a225c_d4d4d4d5.
//  3 Bypass: in_state=00112233_44556677_8899aabb_ccddeeff, bypass=1 -> out_valid 1 cycle
//    after accept, out_state identical to input.
//  4 Backpressure: case 2 with out_ready=0 for 10 cycles -> out_valid and out_state stable,
//    in_ready=0, second in_valid not accepted; out_ready=1 -> IDLE next cycle.
//  5 Identity columns: in_state=01010101_c6c6c6c6_4d7ebdf8_01010101 ->
//    out_state=01010101_c6c6c6c6_2d26314c_01010101.
//  6 Reset mid-RUN: reset on 2nd RUN cycle -> next cycle IDLE, out_valid=0, out_state=0;
//    a fresh case-2 transaction then completes with correct result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES column-sequencer constants, FSM state type and column slicing helper.
package aes_pkg;

    localparam int unsigned COL_W    = 32;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned STATE_W  = NUM_COLS * COL_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    // Column 0 occupies the most significant word (bytes s0..s3).
    function automatic logic [COL_W-1:0] col_sel(input logic [STATE_W-1:0] state,
                                                 input logic [1:0]         idx);
        return state[STATE_W - 1 - COL_W * int'(idx) -: COL_W];
    endfunction

endpackage

// File: rtl/reverse_mix_cols.sv
// Combinational InvMixColumns on one 32-bit column (GF(2^8), 0e/0b/0d/09 matrix).
module reverse_mix_cols (
    input  logic [31:0] input_col,
    output logic [31:0] final_col
);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] b [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            b[i]  = input_col[31 - 8 * i -: 8];
            m2[i] = xt(b[i]);
            m4[i] = xt(m2[i]);
            m8[i] = xt(m4[i]);
            m9[i] = m8[i] ^ b[i];
            mb[i] = m8[i] ^ m2[i] ^ b[i];
            md[i] = m8[i] ^ m4[i] ^ b[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        final_col[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        final_col[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        final_col[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        final_col[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end

endmodule

// File: rtl/inv_mix_cols_sequencer.sv
// Applies one shared reverse_mix_cols to a 128-bit AES state, one column per cycle,
// with valid/ready on both sides and a bypass path for the final decrypt round.
module inv_mix_cols_sequencer
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    fsm_t               state_q, state_d;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [STATE_W-1:0] in_lat_q, in_lat_d;
    logic [STATE_W-1:0] out_state_q, out_state_d;
    logic               out_valid_q, out_valid_d;
    logic [COL_W-1:0]   mix_in, mix_out;
    logic               accept;

    reverse_mix_cols u_mix (
        .input_col (mix_in),
        .final_col (mix_out)
    );

    assign mix_in    = col_sel(in_lat_q, col_idx_q);
    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        in_lat_d    = in_lat_q;
        out_state_d = out_state_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    in_lat_d  = in_state;
                    col_idx_d = 2'd0;
                    if (in_bypass) begin
                        out_state_d = in_state;
                        state_d     = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                out_state_d[STATE_W - 1 - COL_W * int'(col_idx_q) -: COL_W] = mix_out;
                col_idx_d = col_idx_q + 2'd1;
                if (col_idx_q == 2'(NUM_COLS - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // A bypassed state enters DONE straight from IDLE and raises valid a cycle later.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            col_idx_q   <= 2'd0;
            in_lat_q    <= '0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            in_lat_q    <= in_lat_d;
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_inv_mix_cols_sequencer.sv
// Self-checking bench for inv_mix_cols_sequencer: vector table plus handshake corner cases.
module tb_inv_mix_cols_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    inv_mix_cols_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [7];
    logic [127:0] sb_q [$];
    int           n_pass  = 0;
    int           n_total = 0;

    localparam logic [127:0] MixIn  = 128'h416e1899_8e4da1bc_9fdc589d_d5d5d7d6;
    localparam logic [127:0] MixOut = 128'hc9dad76a_db135345_f20a225c_d4d4d4d5;
    localparam logic [127:0] ByIn   = 128'h00112233_44556677_8899aabb_ccddeeff;

    // Reference: generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [7:0]   c    [4];
        logic [7:0]   r;
        logic [127:0] o = '0;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int col = 0; col < 4; col++) begin
            for (int k = 0; k < 4; k++) c[k] = s[127 - 32 * col - 8 * k -: 8];
            for (int row = 0; row < 4; row++) begin
                r = 8'h00;
                for (int k = 0; k < 4; k++) r = r ^ gf_mul(c[k], coef[(k - row + 4) % 4]);
                o[127 - 32 * col - 8 * row -: 8] = r;
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a state, wait (bounded) for acceptance, log the expected result.
    task automatic drive_accept(input logic [127:0] st, input logic byp,
                                input logic [127:0] exp, input string name);
        int w = 0;
        in_state  = st;
        in_bypass = byp;
        in_valid  = 1'b1;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        if (!in_ready) check({name, " accept timeout"}, 128'(in_ready), 128'd1);
        sb_q.push_back(exp);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, " latency"}, 128'(lat), 128'(exp_lat));
    endtask

    task automatic pop_check(input string name);
        if (sb_q.size() == 0) check({name, " scoreboard empty"}, 128'd0, 128'd1);
        else check({name, " data"}, out_state, sb_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r0, r1, r2, hold;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_bypass = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset out_state", out_state, 128'd0);
        reset = 1'b0;
        step();

        r0 = {$urandom, $urandom, $urandom, $urandom};
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        vecs[0] = '{MixIn, 1'b0, MixOut};
        vecs[1] = '{ByIn, 1'b1, ByIn};
        vecs[2] = '{128'h01010101_c6c6c6c6_4d7ebdf8_01010101, 1'b0,
                    128'h01010101_c6c6c6c6_2d26314c_01010101};
        vecs[3] = '{MixIn, 1'b0, model(MixIn)};
        vecs[4] = '{r0, 1'b0, model(r0)};
        vecs[5] = '{r1, 1'b1, r1};
        vecs[6] = '{r2, 1'b0, model(r2)};

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive_accept(vecs[i].st, vecs[i].byp, vecs[i].exp, nm);
            wait_out(nm, vecs[i].byp ? 1 : 4);
            pop_check(nm);
            step();
            check({nm, " idle after handshake"}, 128'(busy), 128'd0);
        end

        // Backpressure: result held, competing bypass request ignored until IDLE.
        out_ready = 1'b0;
        drive_accept(MixIn, 1'b0, MixOut, "bp");
        wait_out("bp", 4);
        hold      = MixOut;
        in_state  = ByIn;
        in_bypass = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp hold valid %0d", i), 128'(out_valid), 128'd1);
            check($sformatf("bp hold data %0d", i), out_state, hold);
            check($sformatf("bp in_ready %0d", i), 128'(in_ready), 128'd0);
            step();
        end
        pop_check("bp");
        out_ready = 1'b1;
        step();
        check("bp idle after release", 128'(busy), 128'd0);
        check("bp valid dropped", 128'(out_valid), 128'd0);
        sb_q.push_back(ByIn);
        step();
        in_valid = 1'b0;
        check("bp late accept", 128'(busy), 128'd1);
        wait_out("bp late", 1);
        pop_check("bp late");
        step();

        // Reset during the second RUN cycle aborts the transaction.
        drive_accept(MixIn, 1'b0, MixOut, "rst");
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst busy", 128'(busy), 128'd0);
        check("rst out_valid", 128'(out_valid), 128'd0);
        check("rst out_state", out_state, 128'd0);
        check("rst in_ready", 128'(in_ready), 128'd1);
        sb_q.delete();
        drive_accept(MixIn, 1'b0, MixOut, "post rst");
        wait_out("post rst", 4);
        pop_check("post rst");
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
